// File: rtl/serial_port_ctrl.sv
// rtl/serial_port_ctrl.sv - memory-mapped serial port controller with TX FIFO and RX holding register (optional IRQ via SERIAL_IRQ_EN)
module serial_port_ctrl #(
    parameter int TX_DEPTH = 8,
    parameter int CNT_W    = $clog2(TX_DEPTH) + 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_sel,
    input  logic [1:0]  cpu_addr,
    input  logic        cpu_wren,
    input  logic        cpu_rden,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    input  logic [7:0]  serial_in,
    input  logic        serial_valid_in,
    input  logic        serial_ready_in,
    output logic        serial_rden_out,
    output logic [7:0]  serial_out,
    output logic        serial_wren_out
`ifdef SERIAL_IRQ_EN
    ,
    output logic        irq_out
`endif
);

    localparam int               PTR_W   = $clog2(TX_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TX_DEPTH);
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_HOLD} rx_state_t;

    logic [7:0]       mem_q [TX_DEPTH];
    logic [7:0]       mem_d [TX_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] tx_count_q, tx_count_d;
    tx_state_t        tx_state_q, tx_state_d;
    logic [7:0]       serial_out_q, serial_out_d;
    logic             serial_wren_q, serial_wren_d;
    rx_state_t        rx_state_q, rx_state_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_full_q, rx_full_d;
    logic             serial_rden_q, serial_rden_d;
    logic [31:0]      cpu_rdata_q, cpu_rdata_d;
    logic             tx_overflow_q, tx_overflow_d;
    logic             tx_en_q, tx_en_d;
    logic             rx_en_q, rx_en_d;
`ifdef SERIAL_IRQ_EN
    logic             rx_irq_en_q, rx_irq_en_d;
    logic             tx_irq_en_q, tx_irq_en_d;
    logic             irq_q, irq_d;
`endif

    logic        wr_sel, rd_sel, data_wr, data_rd;
    logic        tx_full, tx_empty, tx_pop, tx_push;
    logic [31:0] status_word, ctrl_word;
    logic        unused_wdata;

    assign wr_sel   = cpu_sel & cpu_wren;
    assign rd_sel   = cpu_sel & cpu_rden;
    assign data_wr  = wr_sel & (cpu_addr == ADDR_DATA);
    assign data_rd  = rd_sel & (cpu_addr == ADDR_DATA);
    assign tx_full  = (tx_count_q == DEPTH_C);
    assign tx_empty = (tx_count_q == '0);
    // A pop frees a slot on the same edge, so a push into a full FIFO still lands
    assign tx_pop   = (tx_state_q == TX_IDLE) & tx_en_q & ~tx_empty & serial_ready_in;
    assign tx_push  = data_wr & (~tx_full | tx_pop);
    assign unused_wdata = ^cpu_wdata[31:8];

    // Status and control words as software sees them
    always_comb begin
        status_word = 32'b0;
        status_word[0] = tx_full;
        status_word[1] = tx_empty;
        status_word[2] = rx_full_q;
        status_word[3] = tx_overflow_q;
        status_word[8 +: CNT_W] = tx_count_q;
`ifdef SERIAL_IRQ_EN
        ctrl_word = {28'b0, tx_irq_en_q, rx_irq_en_q, rx_en_q, tx_en_q};
`else
        ctrl_word = {30'b0, rx_en_q, tx_en_q};
`endif
    end

    // TX FIFO storage, pointers and occupancy
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tx_count_d = tx_count_q;
        if (tx_push) begin
            mem_d[wr_ptr_q] = cpu_wdata[7:0];
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (tx_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (tx_push && !tx_pop) begin
            tx_count_d = tx_count_q + CNT_W'(1);
        end else if (tx_pop && !tx_push) begin
            tx_count_d = tx_count_q - CNT_W'(1);
        end
    end

    // TX FSM: launch the FIFO head with a one-cycle strobe, then rest a cycle
    always_comb begin
        tx_state_d    = tx_state_q;
        serial_out_d  = serial_out_q;
        serial_wren_d = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_pop) begin
                    tx_state_d    = TX_SEND;
                    serial_out_d  = mem_q[rd_ptr_q];
                    serial_wren_d = 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // RX FSM: pop the source, capture the byte, hold until software reads DATA
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_data_d     = rx_data_q;
        rx_full_d     = rx_full_q;
        serial_rden_d = 1'b0;
        if (data_rd) begin
            rx_full_d = 1'b0;
        end
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_en_q && serial_valid_in && !rx_full_q) begin
                    rx_state_d    = RX_ACK;
                    serial_rden_d = 1'b1;
                end
            end
            RX_ACK: begin
                rx_state_d = RX_HOLD;
                rx_data_d  = serial_in;
                rx_full_d  = 1'b1;
            end
            RX_HOLD: begin
                if (data_rd) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Register file: read mux, control bits, sticky overflow, interrupt
    always_comb begin
        cpu_rdata_d   = cpu_rdata_q;
        tx_overflow_d = tx_overflow_q;
        tx_en_d       = tx_en_q;
        rx_en_d       = rx_en_q;
`ifdef SERIAL_IRQ_EN
        rx_irq_en_d   = rx_irq_en_q;
        tx_irq_en_d   = tx_irq_en_q;
        irq_d         = (rx_full_q & rx_irq_en_q) | (tx_empty & tx_irq_en_q);
`endif
        if (rd_sel) begin
            case (cpu_addr)
                ADDR_DATA:    cpu_rdata_d = {24'b0, rx_data_q};
                ADDR_STATUS:  cpu_rdata_d = status_word;
                ADDR_CONTROL: cpu_rdata_d = ctrl_word;
                default:      cpu_rdata_d = 32'b0;
            endcase
        end
        if (data_wr && tx_full && !tx_pop) begin
            tx_overflow_d = 1'b1;
        end else if (wr_sel && cpu_addr == ADDR_STATUS && cpu_wdata[3]) begin
            tx_overflow_d = 1'b0;
        end
        if (wr_sel && cpu_addr == ADDR_CONTROL) begin
            tx_en_d = cpu_wdata[0];
            rx_en_d = cpu_wdata[1];
`ifdef SERIAL_IRQ_EN
            rx_irq_en_d = cpu_wdata[2];
            tx_irq_en_d = cpu_wdata[3];
`endif
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TX_DEPTH; i++) mem_q[i] <= 8'h00;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tx_count_q    <= '0;
            tx_state_q    <= TX_IDLE;
            serial_out_q  <= 8'h00;
            serial_wren_q <= 1'b0;
            rx_state_q    <= RX_IDLE;
            rx_data_q     <= 8'h00;
            rx_full_q     <= 1'b0;
            serial_rden_q <= 1'b0;
            cpu_rdata_q   <= 32'b0;
            tx_overflow_q <= 1'b0;
            tx_en_q       <= 1'b1;
            rx_en_q       <= 1'b1;
`ifdef SERIAL_IRQ_EN
            rx_irq_en_q   <= 1'b0;
            tx_irq_en_q   <= 1'b0;
            irq_q         <= 1'b0;
`endif
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tx_count_q    <= tx_count_d;
            tx_state_q    <= tx_state_d;
            serial_out_q  <= serial_out_d;
            serial_wren_q <= serial_wren_d;
            rx_state_q    <= rx_state_d;
            rx_data_q     <= rx_data_d;
            rx_full_q     <= rx_full_d;
            serial_rden_q <= serial_rden_d;
            cpu_rdata_q   <= cpu_rdata_d;
            tx_overflow_q <= tx_overflow_d;
            tx_en_q       <= tx_en_d;
            rx_en_q       <= rx_en_d;
`ifdef SERIAL_IRQ_EN
            rx_irq_en_q   <= rx_irq_en_d;
            tx_irq_en_q   <= tx_irq_en_d;
            irq_q         <= irq_d;
`endif
        end
    end

    assign cpu_rdata       = cpu_rdata_q;
    assign serial_out      = serial_out_q;
    assign serial_wren_out = serial_wren_q;
    assign serial_rden_out = serial_rden_q;
`ifdef SERIAL_IRQ_EN
    assign irq_out         = irq_q;
`endif

endmodule

// File: tb/tb_serial_port_ctrl.sv
// tb/tb_serial_port_ctrl.sv - self-checking bench for serial_port_ctrl
module tb_serial_port_ctrl;

    localparam int TX_DEPTH = 8;

    logic        clock;
    logic        reset;
    logic        cpu_sel;
    logic [1:0]  cpu_addr;
    logic        cpu_wren;
    logic        cpu_rden;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic [7:0]  serial_in;
    logic        serial_valid_in;
    logic        serial_ready_in;
    logic        serial_rden_out;
    logic [7:0]  serial_out;
    logic        serial_wren_out;
`ifdef SERIAL_IRQ_EN
    logic        irq_out;
`endif

    serial_port_ctrl #(.TX_DEPTH(TX_DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .cpu_sel         (cpu_sel),
        .cpu_addr        (cpu_addr),
        .cpu_wren        (cpu_wren),
        .cpu_rden        (cpu_rden),
        .cpu_wdata       (cpu_wdata),
        .cpu_rdata       (cpu_rdata),
        .serial_in       (serial_in),
        .serial_valid_in (serial_valid_in),
        .serial_ready_in (serial_ready_in),
        .serial_rden_out (serial_rden_out),
        .serial_out      (serial_out),
        .serial_wren_out (serial_wren_out)
`ifdef SERIAL_IRQ_EN
        ,
        .irq_out         (irq_out)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t       vt [16];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         tx_pulses = 0;
    int         rx_pulses = 0;
    int         rden_cyc = 0;
    int         last_wr_cyc = 0;
    int         pulse_cyc [$];
    logic [7:0] exp_q [$];
    logic       prev_wren = 1'b0;
    logic       prev_rden = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        cpu_sel = 1'b1; cpu_wren = 1'b1; cpu_addr = a; cpu_wdata = d;
        if (a == 2'd0 && exp_q.size() < TX_DEPTH) exp_q.push_back(d[7:0]);
        @(posedge clock); #1;
        last_wr_cyc = cyc;
        cpu_sel = 1'b0; cpu_wren = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        cpu_sel = 1'b1; cpu_rden = 1'b1; cpu_addr = a;
        @(posedge clock); #1;
        cpu_sel = 1'b0; cpu_rden = 1'b0;
        d = cpu_rdata;
    endtask

    task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        cpu_read(a, d);
        chk(name, d, exp);
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_tx(input string name, input int n);
        int k = 0;
        while (tx_pulses < n && k < 100) begin
            @(posedge clock); #1;
            k++;
        end
        chk(name, 32'(tx_pulses), 32'(n));
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard side: every write strobe must match the oldest accepted byte
    always @(negedge clock) begin
        if (reset) begin
            if (serial_wren_out) begin
                chk("wren_width", {31'b0, prev_wren}, 32'd0);
                tx_pulses++;
                pulse_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL tx_unexpected: got byte 0x%02h, expected no strobe", serial_out);
                end else begin
                    chk("tx_byte", {24'b0, serial_out}, {24'b0, exp_q.pop_front()});
                end
            end
            if (serial_rden_out) begin
                chk("rden_width", {31'b0, prev_rden}, 32'd0);
                rx_pulses++;
                rden_cyc = cyc;
            end
        end
        prev_wren = serial_wren_out;
        prev_rden = serial_rden_out;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int w0;
        int k;
        logic [31:0] ctrl_f;
`ifdef SERIAL_IRQ_EN
        ctrl_f = 32'hF;
`else
        ctrl_f = 32'h3;
`endif
        vt[0]  = '{1'b0, 2'd1, 32'h0,        32'h2};
        vt[1]  = '{1'b0, 2'd2, 32'h0,        32'h3};
        vt[2]  = '{1'b0, 2'd3, 32'h0,        32'h0};
        vt[3]  = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h0};
        vt[4]  = '{1'b0, 2'd3, 32'h0,        32'h0};
        vt[5]  = '{1'b0, 2'd1, 32'h0,        32'h2};
        vt[6]  = '{1'b1, 2'd2, 32'hF0,       32'h0};
        vt[7]  = '{1'b0, 2'd2, 32'h0,        32'h0};
        vt[8]  = '{1'b1, 2'd2, 32'hF,        32'h0};
        vt[9]  = '{1'b0, 2'd2, 32'h0,        ctrl_f};
        vt[10] = '{1'b1, 2'd2, 32'h3,        32'h0};
        vt[11] = '{1'b1, 2'd1, 32'hFFFFFFFF, 32'h0};
        vt[12] = '{1'b0, 2'd1, 32'h0,        32'h2};
        vt[13] = '{1'b0, 2'd2, 32'h0,        32'h3};
        vt[14] = '{1'b0, 2'd0, 32'h0,        32'h0};
        vt[15] = '{1'b0, 2'd1, 32'h0,        32'h2};

        reset = 1'b0; cpu_sel = 1'b0; cpu_addr = 2'd0; cpu_wren = 1'b0; cpu_rden = 1'b0;
        cpu_wdata = 32'b0; serial_in = 8'h00; serial_valid_in = 1'b0; serial_ready_in = 1'b0;

        // Reset held for 10 cycles: strobes stay low throughout
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("rst_wren", {31'b0, serial_wren_out}, 32'd0);
            chk("rst_rden", {31'b0, serial_rden_out}, 32'd0);
        end
        chk("rst_serial_out", {24'b0, serial_out}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
`ifdef SERIAL_IRQ_EN
        chk("rst_irq", {31'b0, irq_out}, 32'd0);
`endif
        reset = 1'b1;
        @(posedge clock); #1;

        // Register map vectors
        for (int i = 0; i < 16; i++) begin
            if (vt[i].wr) cpu_write(vt[i].addr, vt[i].wdata);
            else read_chk($sformatf("vec%0d", i), vt[i].addr, vt[i].exp);
        end

        // Transmit two bytes back to back
        serial_ready_in = 1'b1;
        base = tx_pulses;
        cpu_write(2'd0, 32'h48);
        w0 = last_wr_cyc;
        cpu_write(2'd0, 32'h69);
        wait_tx("tx_two_pulses", base + 2);
        if (pulse_cyc.size() >= base + 2) begin
            chk("tx_latency", 32'(pulse_cyc[base] - w0), 32'd1);
            chk("tx_spacing", 32'(pulse_cyc[base + 1] - pulse_cyc[base]), 32'd2);
        end
        read_chk("tx_status_end", 2'd1, 32'h002);

        // tx_en cleared: byte stays queued until re-enabled
        cpu_write(2'd2, 32'h2);
        base = tx_pulses;
        cpu_write(2'd0, 32'h33);
        cyc_wait(6);
        chk("txen_hold", 32'(tx_pulses), 32'(base));
        read_chk("txen_status", 2'd1, 32'h100);
        cpu_write(2'd2, 32'h3);
        wait_tx("txen_resume", base + 1);

        // Overflow: 9 writes into an 8-entry FIFO with the sink stalled
        serial_ready_in = 1'b0;
        for (int i = 1; i <= 9; i++) cpu_write(2'd0, 32'(i));
        read_chk("ovf_status", 2'd1, 32'h809);
        cpu_write(2'd1, 32'h8);
        read_chk("ovf_cleared", 2'd1, 32'h801);
        base = tx_pulses;
        serial_ready_in = 1'b1;
        wait_tx("ovf_drain", base + 8);
        cyc_wait(10);
        chk("ovf_no_ninth", 32'(tx_pulses), 32'(base + 8));
        read_chk("ovf_status_end", 2'd1, 32'h002);

        // Receive: one pop, hold while full, new pop after DATA read
        base = rx_pulses;
        serial_in = 8'h41;
        serial_valid_in = 1'b1;
        cyc_wait(10);
        chk("rx_one_pulse", 32'(rx_pulses), 32'(base + 1));
        read_chk("rx_status_full", 2'd1, 32'h006);
        cyc_wait(5);
        chk("rx_no_pulse_full", 32'(rx_pulses), 32'(base + 1));
        read_chk("rx_data", 2'd0, 32'h41);
        k = 0;
        while (rx_pulses < base + 2 && k < 10) begin
            @(posedge clock); #1;
            k++;
        end
        chk("rx_repulse", 32'(rx_pulses), 32'(base + 2));
        serial_valid_in = 1'b0;
        cyc_wait(2);
        read_chk("rx_data2", 2'd0, 32'h41);
        read_chk("rx_status_clear", 2'd1, 32'h002);
        read_chk("rx_stale_read", 2'd0, 32'h41);
        chk("rx_total", 32'(rx_pulses), 32'(base + 2));

`ifdef SERIAL_IRQ_EN
        // Interrupt follows rx_full with one register stage
        cpu_write(2'd2, 32'h7);
        serial_in = 8'h5A;
        serial_valid_in = 1'b1;
        k = 0;
        while (!irq_out && k < 20) begin
            @(posedge clock); #1;
            k++;
        end
        chk("irq_rise", {31'b0, irq_out}, 32'd1);
        chk("irq_latency", 32'(cyc - rden_cyc), 32'd2);
        serial_valid_in = 1'b0;
        read_chk("irq_data", 2'd0, 32'h5A);
        chk("irq_hold", {31'b0, irq_out}, 32'd1);
        @(posedge clock); #1;
        chk("irq_fall", {31'b0, irq_out}, 32'd0);
        cpu_write(2'd2, 32'h3);
`endif

        // Reset asserted while a byte is being strobed
        serial_ready_in = 1'b0;
        cpu_write(2'd0, 32'hA1);
        cpu_write(2'd0, 32'hA2);
        cpu_write(2'd0, 32'hA3);
        serial_ready_in = 1'b1;
        k = 0;
        while (!serial_wren_out && k < 20) begin
            @(posedge clock); #1;
            k++;
        end
        chk("midop_wren_seen", {31'b0, serial_wren_out}, 32'd1);
        #2 reset = 1'b0;
        exp_q.delete();
        #1;
        chk("midop_async_wren", {31'b0, serial_wren_out}, 32'd0);
        chk("midop_serial_out", {24'b0, serial_out}, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        base = tx_pulses;
        read_chk("midop_status", 2'd1, 32'h002);
        cyc_wait(10);
        chk("midop_no_tx", 32'(tx_pulses), 32'(base));

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
